// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path:
//   - state_t           : receiver FSM state encoding
//   - BAUD_W            : width of the bit-period counter
//   - DATA_BITS_8/7     : frame-length constants (data bits per character)
//   - LAST_BIT_8/7      : bit-counter value of the final data bit
//   - baud_period()     : baud_val -> bit period in 100 MHz clocks
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // 333333 clocks (300 baud) is the longest period and needs 19 bits.
    localparam int BAUD_W = 19;

    localparam int BIT_CNT_W   = 3;
    localparam int DATA_BITS_8 = 8;
    localparam int DATA_BITS_7 = 7;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT_8 = BIT_CNT_W'(DATA_BITS_8 - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT_7 = BIT_CNT_W'(DATA_BITS_7 - 1);

    // Bit period in clock cycles at 100 MHz for each baud selection.
    function automatic logic [BAUD_W-1:0] baud_period(input logic [3:0] sel);
        case (sel)
            4'd0:    baud_period = BAUD_W'(333333);
            4'd1:    baud_period = BAUD_W'(83333);
            4'd2:    baud_period = BAUD_W'(41667);
            4'd3:    baud_period = BAUD_W'(20833);
            4'd4:    baud_period = BAUD_W'(10417);
            4'd5:    baud_period = BAUD_W'(5208);
            4'd6:    baud_period = BAUD_W'(2604);
            4'd7:    baud_period = BAUD_W'(1736);
            4'd8:    baud_period = BAUD_W'(868);
            4'd9:    baud_period = BAUD_W'(434);
            4'd10:   baud_period = BAUD_W'(217);
            default: baud_period = BAUD_W'(109);
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// -----------------------------------------------------------------------------
// uart_baud_cnt
// Down-counter that produces one-cycle ticks spaced by 'period' clocks.
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   period : bit period in clocks (must be >= 2)
//   load   : restart the count this cycle (suppresses tick)
//   half   : with load, the first tick comes after period/2 clocks
//   tick   : one-cycle pulse at the end of each (half) period
// After a tick the counter reloads a full period by itself, so a single
// half-period load lands every later tick in the middle of a bit.
// -----------------------------------------------------------------------------
module uart_baud_cnt
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [BAUD_W-1:0] period,
    input  logic              load,
    input  logic              half,
    output logic              tick
);

    logic [BAUD_W-1:0] cnt_reg;
    logic [BAUD_W-1:0] cnt_next;

    assign tick = (cnt_reg == '0) && !load;

    always_comb begin
        cnt_next = cnt_reg - 1'b1;
        if (load) begin
            cnt_next = (half ? (period >> 1) : period) - 1'b1;
        end else if (cnt_reg == '0) begin
            cnt_next = period - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/uart_rx_engine.sv
// -----------------------------------------------------------------------------
// uart_rx_engine
// UART receiver: 7/8 data bits, optional parity bit, one stop bit.
//   clk        : 100 MHz system clock
//   reset      : asynchronous active-low reset
//   rx         : serial input, idle high, asynchronous to clk
//   bit8       : 1 = 8 data bits, 0 = 7 data bits (rx_data[7] = 0)
//   parity_en  : a parity bit follows the data bits
//   odd_n_even : 1 = odd parity, 0 = even parity
//   baud_val   : baud-rate select (see uart_pkg::baud_period)
//   rd_ack     : one-cycle pulse, consumer has read rx_data
//   rx_data    : last received character
//   rxrdy      : character available
//   perr/ferr/ovf : parity error, framing error, overrun
// Build option: UART_RX_PARITY_CHECK_EN enables the parity check. Without it
// the parity bit is still consumed but perr is tied low.
// Frame settings are captured when a start bit is detected, so changing them
// mid-frame only affects the next character.
// -----------------------------------------------------------------------------
module uart_rx_engine
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic [3:0] baud_val,
    input  logic       rd_ack,
    output logic [7:0] rx_data,
    output logic       rxrdy,
    output logic       perr,
    output logic       ferr,
    output logic       ovf
);

    logic rx_meta_reg;
    logic rx_sync_reg;

    state_t state_reg;
    state_t state_next;

    logic [BAUD_W-1:0]    period_reg;
    logic                 bit8_reg;
    logic                 parity_en_reg;
    logic [BIT_CNT_W-1:0] bit_cnt_reg;
    logic [7:0]           shift_reg;
    logic                 wait_high_reg;

    logic [7:0] rx_data_reg;
    logic       rxrdy_reg;
    logic       ferr_reg;
    logic       ovf_reg;

    logic [BAUD_W-1:0]    cnt_period;
    logic                 cnt_load;
    logic                 cnt_half;
    logic                 tick;
    logic                 frame_done;
    logic                 start_det;
    logic [BIT_CNT_W-1:0] last_bit;

    // Two-flop synchronizer; reset value is the idle (high) line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
        end
    end

    // While idle the live baud selection feeds the counter so the half-bit
    // load at start detection already uses the new rate.
    assign cnt_period = (state_reg == ST_IDLE) ? baud_period(baud_val) : period_reg;
    assign last_bit   = bit8_reg ? LAST_BIT_8 : LAST_BIT_7;

    uart_baud_cnt u_baud_cnt (
        .clk    (clk),
        .reset  (reset),
        .period (cnt_period),
        .load   (cnt_load),
        .half   (cnt_half),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_load   = 1'b0;
        cnt_half   = 1'b0;
        frame_done = 1'b0;
        start_det  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!wait_high_reg && !rx_sync_reg) begin
                    state_next = ST_START;
                    cnt_load   = 1'b1;
                    cnt_half   = 1'b1;
                    start_det  = 1'b1;
                end
            end
            ST_START: begin
                // High at mid start bit is a glitch: drop it silently.
                if (tick) begin
                    state_next = rx_sync_reg ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick && (bit_cnt_reg == last_bit)) begin
                    state_next = parity_en_reg ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_next = ST_IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Frame datapath: settings capture, bit collection, break handling.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_reg    <= '0;
            bit8_reg      <= 1'b0;
            parity_en_reg <= 1'b0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            wait_high_reg <= 1'b1;
        end else begin
            if (start_det) begin
                period_reg    <= baud_period(baud_val);
                bit8_reg      <= bit8;
                parity_en_reg <= parity_en;
                bit_cnt_reg   <= '0;
                shift_reg     <= '0;
            end
            if ((state_reg == ST_DATA) && tick) begin
                shift_reg[bit_cnt_reg] <= rx_sync_reg;
                bit_cnt_reg            <= bit_cnt_reg + 1'b1;
            end
            // A low stop bit (break) or a fresh reset must see the line
            // return high before another start bit is accepted.
            if (frame_done && !rx_sync_reg) begin
                wait_high_reg <= 1'b1;
            end else if ((state_reg == ST_IDLE) && rx_sync_reg) begin
                wait_high_reg <= 1'b0;
            end
        end
    end

    // Completion wins over a simultaneous rd_ack; overrun only counts when
    // the previous character was still unread at completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data_reg <= 8'h00;
            rxrdy_reg   <= 1'b0;
            ferr_reg    <= 1'b0;
            ovf_reg     <= 1'b0;
        end else if (frame_done) begin
            rx_data_reg <= shift_reg;
            rxrdy_reg   <= 1'b1;
            ferr_reg    <= ~rx_sync_reg;
            ovf_reg     <= rxrdy_reg & ~rd_ack;
        end else if (rd_ack) begin
            rxrdy_reg <= 1'b0;
            ferr_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_CHECK_EN
    logic odd_reg;
    logic perr_pend_reg;
    logic perr_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            odd_reg       <= 1'b0;
            perr_pend_reg <= 1'b0;
            perr_reg      <= 1'b0;
        end else begin
            if (start_det) begin
                odd_reg       <= odd_n_even;
                perr_pend_reg <= 1'b0;
            end
            // Expected parity bit = XOR of data bits, inverted for odd.
            if ((state_reg == ST_PARITY) && tick) begin
                perr_pend_reg <= rx_sync_reg ^ (^shift_reg) ^ odd_reg;
            end
            if (frame_done) begin
                perr_reg <= perr_pend_reg;
            end else if (rd_ack) begin
                perr_reg <= 1'b0;
            end
        end
    end

    assign perr = perr_reg;
`else
    logic unused_parity;
    assign unused_parity = &{1'b0, odd_n_even};
    assign perr = 1'b0;
`endif

    assign rx_data = rx_data_reg;
    assign rxrdy   = rxrdy_reg;
    assign ferr    = ferr_reg;
    assign ovf     = ovf_reg;

endmodule
